// File: rtl/pdm.sv
// Payload soft demapper: keeps the data subcarriers of each OFDM symbol and emits
// saturated soft bits through a small FWFT FIFO. `PDM_16QAM_EN builds the b2/b3 path.
module pdm #(
  parameter int N          = 512,
  parameter int DATA_START = 16,
  parameter int DATA_END   = 494,
  parameter int SHIFT      = 6,
  parameter int SW         = 6,
  parameter int QAM_THR    = 2048,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [13:0]        di_re,
  input  logic [13:0]        di_im,
  input  logic               di_vld,
  input  logic               mod_sel,
  output logic [4*SW-1:0]    do_llr,
  output logic               do_last,
  output logic               do_vld,
  input  logic               do_rdy,
  output logic               ovf
);
  localparam int LW = 4 * SW;
  localparam int EW = LW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [15:0] SMAX = 16'((1 << (SW - 1)) - 1);
  localparam logic signed [15:0] SMIN = -SMAX;

  // Symmetric clamp: -2^(SW-1) is never produced.
  function automatic logic [SW-1:0] sat(input logic signed [15:0] v);
    logic signed [15:0] s;
    s = v >>> SHIFT;
    if (s > SMAX)      sat = SW'(SMAX);
    else if (s < SMIN) sat = SW'(SMIN);
    else               sat = SW'(s);
  endfunction

  logic [9:0]  cnt;
  logic        kept;
  logic        s1_vld, s1_last;
  logic [13:0] s1_re, s1_im;

  always_comb kept = di_vld && (cnt >= 10'(DATA_START)) && (cnt <= 10'(DATA_END));

  // Any gap in di_vld realigns the symbol so the next valid sample is index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_re   <= '0;
      s1_im   <= '0;
    end else begin
      if (di_vld) cnt <= (cnt == 10'(N - 1)) ? '0 : cnt + 10'd1;
      else        cnt <= '0;
      s1_vld  <= kept;
      s1_last <= kept && (cnt == 10'(DATA_END));
      s1_re   <= di_re;
      s1_im   <= di_im;
    end
  end

  logic signed [15:0] re16, im16;
  logic [LW-1:0]      llr;

  always_comb begin
    re16 = {{2{s1_re[13]}}, s1_re};
    im16 = {{2{s1_im[13]}}, s1_im};
  end

`ifdef PDM_16QAM_EN
  logic               s1_mod;
  logic [14:0]        re_ext, im_ext, re_abs, im_abs;
  logic signed [15:0] re_diff, im_diff;

  always_ff @(posedge clk) begin
    if (rst) s1_mod <= 1'b0;
    else     s1_mod <= mod_sel;
  end

  always_comb begin
    re_ext  = {s1_re[13], s1_re};
    im_ext  = {s1_im[13], s1_im};
    re_abs  = re_ext[14] ? (~re_ext + 15'd1) : re_ext;
    im_abs  = im_ext[14] ? (~im_ext + 15'd1) : im_ext;
    re_diff = $signed(16'(QAM_THR)) - $signed({1'b0, re_abs});
    im_diff = $signed(16'(QAM_THR)) - $signed({1'b0, im_abs});
    llr     = '0;
    llr[SW-1:0]    = sat(re16);
    llr[2*SW-1:SW] = sat(im16);
    if (s1_mod) begin
      llr[3*SW-1:2*SW] = sat(re_diff);
      llr[4*SW-1:3*SW] = sat(im_diff);
    end
  end
`else
  logic unused_mod;
  assign unused_mod = mod_sel;

  always_comb begin
    llr = '0;
    llr[SW-1:0]    = sat(re16);
    llr[2*SW-1:SW] = sat(im16);
  end
`endif

  // FWFT FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, rd_en, wr_en;
  logic [EW-1:0] head;

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_en = !empty && do_rdy;
    wr_en = s1_vld && (!full || rd_en);
    head  = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s1_last, llr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (s1_vld && full && !rd_en) ovf <= 1'b1;
    end
  end

  always_comb begin
    do_vld  = !empty;
    do_llr  = empty ? '0 : head[LW-1:0];
    do_last = !empty && head[LW];
  end
endmodule

// File: tb/tb_pdm.sv
// Self-checking bench for pdm: random and directed stimulus, spec-level reference
// model feeding an expected-word queue, and a negedge monitor. Honours `PDM_16QAM_EN.
module tb_pdm;
  localparam int N = 512, DATA_START = 16, DATA_END = 494, SHIFT = 6, SW = 6;
  localparam int QAM_THR = 2048, FIFO_DEPTH = 16, LW = 4 * SW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [13:0] di_re = '0, di_im = '0;
  logic              di_vld = 1'b0, mod_sel = 1'b0, do_rdy = 1'b0;
  logic [LW-1:0]     do_llr;
  logic              do_last, do_vld, ovf;

  pdm dut (
    .clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
    .mod_sel(mod_sel), .do_llr(do_llr), .do_last(do_last), .do_vld(do_vld),
    .do_rdy(do_rdy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int words = 0, lasts = 0;
  logic mon_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic int sat_ref(int v);
    int s;
    s = v >>> SHIFT;
    if (s > 31) return 31;
    if (s < -31) return -31;
    return s;
  endfunction

  function automatic logic [LW:0] ref_word(int re, int im, logic m, logic last);
    int b0, b1, b2, b3;
    logic [LW-1:0] w;
    b0 = sat_ref(re);
    b1 = sat_ref(im);
    b2 = 0;
    b3 = 0;
`ifdef PDM_16QAM_EN
    if (m) begin
      b2 = sat_ref(QAM_THR - ((re < 0) ? -re : re));
      b3 = sat_ref(QAM_THR - ((im < 0) ? -im : im));
    end
`endif
    w = {6'(b3), 6'(b2), 6'(b1), 6'(b0)};
    return {last, w};
  endfunction

  logic [LW:0] exp_q[$];
  int          m_idx = 0, m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic        p_vld = 1'b0;
  logic [LW:0] p_word = '0;

  // Index = position since the last gap, modulo N; words enter the FIFO one
  // cycle after capture and are dropped only when it has no free slot.
  always @(posedge clk) begin
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_ovf = 1'b0; p_vld = 1'b0;
      exp_q.delete();
    end else begin
      logic rd;
      int idx;
      rd = (m_cnt > 0) && do_rdy;
      if (p_vld) begin
        if (m_cnt < FIFO_DEPTH || rd) begin
          exp_q.push_back(p_word);
          m_cnt++;
        end else m_ovf = 1'b1;
      end
      if (rd) m_cnt--;
      p_vld = 1'b0;
      if (di_vld) begin
        idx = m_idx;
        m_idx = (m_idx + 1) % N;
        if (idx >= DATA_START && idx <= DATA_END) begin
          p_vld  = 1'b1;
          p_word = ref_word(int'(di_re), int'(di_im), mod_sel, idx == DATA_END);
        end
      end else m_idx = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("do_vld", {31'd0, do_vld}, {31'd0, m_cnt > 0});
      chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      if (!do_vld) chk("last_without_vld", {31'd0, do_last}, 32'd0);
      if (do_vld && do_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'd1, 32'd0);
        else begin
          logic [LW:0] e;
          e = exp_q.pop_front();
          chk("do_llr", 32'(do_llr), 32'(e[LW-1:0]));
          chk("do_last", {31'd0, do_last}, {31'd0, e[LW]});
        end
        words++;
        if (do_last) lasts++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(logic v, int re, int im, logic m, logic r);
    di_vld  = v;
    di_re   = 14'(re);
    di_im   = 14'(im);
    mod_sel = m;
    do_rdy  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_sample(logic r);
    drive(1'b1, $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
          1'($urandom_range(0, 1)), r);
  endtask

  task automatic idle(int n, logic r);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, r);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    idle(2, 1'b0);
    rst = 1'b0;
  endtask

  int base_w, base_l;

  initial begin
    mon_en = 1'b1;
    pulse_rst();
    @(negedge clk);
    chk("rst_do_vld", {31'd0, do_vld}, 32'd0);
    chk("rst_do_llr", 32'(do_llr), 32'd0);
    chk("rst_do_last", {31'd0, do_last}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;

    // Head-of-FIFO directed value, mod_sel = 1.
    for (int i = 0; i < 16; i++) rand_sample(1'b0);
    drive(1'b1, 1000, -3000, 1'b1, 1'b0);
    idle(3, 1'b0);
    chk("dir_vld", {31'd0, do_vld}, 32'd1);
`ifdef PDM_16QAM_EN
    chk("dir_16qam_llr", 32'(do_llr), 32'({6'h31, 6'h10, 6'h21, 6'h0F}));
`else
    chk("dir_qpsk_llr", 32'(do_llr), 32'({6'h00, 6'h00, 6'h21, 6'h0F}));
`endif
    idle(4, 1'b1);

    // Full symbol, QPSK scaling points at indices 16 and 17.
    base_w = words; base_l = lasts;
    for (int i = 0; i < N; i++) begin
      if (i == 16)      drive(1'b1, 1000, -5000, 1'b0, 1'b1);
      else if (i == 17) drive(1'b1, 3000, 0, 1'b0, 1'b1);
      else              rand_sample(1'b1);
    end
    idle(4, 1'b1);
    chk("symbol_words", 32'(words - base_w), 32'd479);
    chk("symbol_lasts", 32'(lasts - base_l), 32'd1);

    // Gap realignment with random backpressure.
    for (int i = 0; i < 100; i++) rand_sample(1'($urandom_range(0, 3) != 0));
    idle(1, 1'b1);
    for (int i = 0; i < 300; i++) rand_sample(1'($urandom_range(0, 3) != 0));
    idle(40, 1'b1);

    // Overflow: no reads for a whole symbol.
    pulse_rst();
    base_w = words;
    for (int i = 0; i < N; i++) rand_sample(1'b0);
    idle(2, 1'b0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    idle(24, 1'b1);
    chk("ovf_drain_words", 32'(words - base_w), 32'd16);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    pulse_rst();
    @(negedge clk);
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;

    // Full FIFO with a read on the same edge as the write.
    base_w = words;
    for (int i = 0; i < 33; i++) rand_sample(1'b0);
    for (int i = 33; i < 61; i++) rand_sample(1'b1);
    idle(24, 1'b1);
    chk("full_rw_ovf", {31'd0, ovf}, 32'd0);
    chk("full_rw_words", 32'(words - base_w), 32'd45);

    // Random symbols with random backpressure, mode and occasional gaps.
    pulse_rst();
    for (int i = 0; i < 3 * N; i++) begin
      if ($urandom_range(0, 199) == 0) idle(1, 1'($urandom_range(0, 1)));
      else rand_sample(1'($urandom_range(0, 3) != 0));
    end

    // Bounded final drain.
    for (int i = 0; i < 64 && (exp_q.size() != 0 || m_cnt != 0); i++) idle(1, 1'b1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pdm.md
# pdm

Payload soft demapper, directly downstream of the payload constellation de-scrambler. It consumes the de-scrambled 14-bit I/Q stream and keeps only the payload data subcarriers of each OFDM symbol. For each kept sample it produces saturated soft bits, which it buffers in a small FIFO and hands to the decoder over a valid/ready handshake.

## Interface
Parameters:
- N, 512, samples per OFDM symbol.
- DATA_START, 16, first data subcarrier index (inclusive).
- DATA_END, 494, last data subcarrier index (inclusive).
- SHIFT, 6, arithmetic right shift applied before saturation.
- SW, 6, soft-bit width (signed).
- QAM_THR, 2048, 16QAM inner/outer decision threshold (14-bit unsigned).
- FIFO_DEPTH, 16, output FIFO entries (power of two).

Ports:
- clk  in  1  working clock.
- rst  in  1  reset: synchronous, active-high.
- di_re  in  14  de-scrambled real part (signed).
- di_im  in  14  de-scrambled imaginary part (signed).
- di_vld  in  1  di_re/di_im valid; no backpressure upstream.
- mod_sel  in  1  0 = QPSK, 1 = 16QAM; sampled per sample; ignored unless PDM_16QAM_EN.
- do_llr  out  4*SW  soft bits {b3,b2,b1,b0}, b0 in LSBs.
- do_last  out  1  marks the soft-bit word for sample DATA_END.
- do_vld  out  1  do_llr/do_last valid.
- do_rdy  in  1  downstream ready.
- ovf  out  1  sticky overflow flag.

## Operation
- Sample index counter cnt (10 bit):
  - Reset value 0.
  - On di_vld: the sample takes index cnt; cnt increments, wrapping N-1 → 0.
  - On !di_vld: cnt cleared to 0, so the first valid sample after any gap is index 0.
- A sample is kept iff di_vld and DATA_START ≤ index ≤ DATA_END (479 samples per symbol by default). All other samples are discarded.
- Soft-bit convention: positive = bit 0 more likely.
  - b0 = sat(di_re >>> SHIFT).
  - b1 = sat(di_im >>> SHIFT).
- With PDM_16QAM_EN and mod_sel = 1:
  - b2 = sat((QAM_THR − |di_re|) >>> SHIFT).
  - b3 = sat((QAM_THR − |di_im|) >>> SHIFT).
  - |x| is computed in 15 bits (|−8192| = 8192); the difference is computed in 16 bits.
- In QPSK mode, b2 and b3 are 0.
- sat() clamps symmetrically to [−(2^(SW−1)−1), +(2^(SW−1)−1)], i.e. ±31 for SW = 6. The value −32 is never produced.
- Pipeline:
  - S1 registers the inputs, kept flag, last flag and mod_sel.
  - S2 shifts, saturates and writes the FIFO.
- FIFO:
  - Entries are {last, llr}.
  - Write when the S2 entry is valid and the FIFO is not full. If full, the word is dropped and ovf is set (sticky; cleared only by rst).
  - Read when do_vld && do_rdy.
  - A simultaneous read and write when full succeeds: the read frees the slot first, and ovf is not set.
- Output is first-word-fall-through: do_vld = !empty, and do_llr/do_last show the head entry.
- Reset values: do_llr 0, do_last 0, do_vld 0, ovf 0. Reset also empties the FIFO and flushes S1/S2.
- rst asserted mid-symbol: all in-flight words are lost. The next di_vld sample is treated as index 0.

## Timing
- Latency: a kept sample at cycle t appears on do_vld at t+2 when the FIFO is empty, independent of do_rdy.
- Throughput: one word per cycle while do_rdy is held high.
- do_llr and do_last hold stable while do_vld && !do_rdy.
- do_last is asserted only with do_vld, on exactly one word per symbol.
- mod_sel is sampled in S1 together with its sample. Changing it mid-symbol takes effect on the next sample.

## Configuration
- PDM_16QAM_EN defined: the b2/b3 datapath is built and mod_sel selects QPSK or 16QAM.
- PDM_16QAM_EN undefined: the b2/b3 logic is removed, mod_sel is ignored, and do_llr[4*SW−1:2*SW] is tied to 0.

## Test plan
- QPSK scaling: a sample at index 16 with di_re = 1000, di_im = −5000 gives b0 = 15, b1 = −31. With di_re = 3000, b0 = 31.
- Window: 512 contiguous valid samples with do_rdy = 1 give exactly 479 words. The first word comes from index 16, and do_last is set only on the index-494 word, 2 cycles after its input.
- Gap realignment: drop di_vld for 1 cycle after 100 samples, then resume. The resumed sample is index 0, and the first kept word is the 17th sample after the gap.
- Backpressure/overflow: do_rdy = 0 for a whole symbol. After 16 words the FIFO is full and ovf = 1. Release do_rdy: exactly 16 words drain in order. ovf stays 1 until rst.
- Full with simultaneous read/write: FIFO full, do_rdy = 1, kept sample arriving. The word is accepted and ovf stays 0.
- 16QAM (PDM_16QAM_EN): mod_sel = 1, di_re = 1000, di_im = −3000 give b0 = 15, b1 = −47 → −31, b2 = 16, b3 = −15. With the macro undefined, the same stimulus gives b2 = b3 = 0.
